present_decrypt: RTL and testbench

- Iterative PRESENT-80 block decryptor. Inverse of present_encrypt: takes a 64-bit ciphertext and an 80-bit user key, and returns the 64-bit plaintext.
- Sits on the receive side of the crypto path. Its output feeds downstream message consumers (e.g. the Hamming decode/check stage).
- Runs one round per clock. An internal forward key-expansion pass derives K32, then the rounds run in reverse order.

---
 rtl/present_decrypt.sv | 161 ++++++++++++++++
 tb/tb_present_decrypt.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 block decryptor: a forward key-expansion pass derives K32,
// then the 31 rounds are undone in reverse order, one per clock.
module present_decrypt (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] cipher,
   input  logic [79:0] key,
   output logic        busy,
   output logic        ready,
   output logic [63:0] msg
);

   typedef enum logic [2:0] {
      IDLE,
      KEYEXP,
      WHITEN,
      DEC,
      DONE
   } state_t;

   state_t      state_reg;
   logic [79:0] key_reg;
   logic [63:0] data_reg;
   logic [4:0]  cnt_reg;

   logic [63:0] pinv_out;
   logic [63:0] round_out;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;
         4'h1: y = 4'hE;
         4'h2: y = 4'hF;
         4'h3: y = 4'h8;
         4'h4: y = 4'hC;
         4'h5: y = 4'h1;
         4'h6: y = 4'h2;
         4'h7: y = 4'hD;
         4'h8: y = 4'hB;
         4'h9: y = 4'h4;
         4'hA: y = 4'h6;
         4'hB: y = 4'h3;
         4'hC: y = 4'h0;
         4'hD: y = 4'h7;
         4'hE: y = 4'h9;
         default: y = 4'hA;
      endcase
      return y;
   endfunction

   // Forward schedule step: K_{i+1} from K_i.
   function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] i);
      logic [79:0] r;
      r = {k[18:0], k[79:19]};
      r[79:76] = sbox(r[79:76]);
      r[19:15] = r[19:15] ^ i;
      return r;
   endfunction

   // Exact inverse of key_fwd: K_i from K_{i+1}.
   function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] i);
      logic [79:0] r;
      r = k;
      r[19:15] = r[19:15] ^ i;
      r[79:76] = sbox_inv(r[79:76]);
      return {r[60:0], r[79:61]};
   endfunction

   // Inverse bit permutation: output bit j takes input bit 16*j mod 63.
   generate
      for (genvar gi = 0; gi < 63; gi++) begin : g_pinv
         assign pinv_out[gi] = data_reg[(16 * gi) % 63];
      end
   endgenerate
   assign pinv_out[63] = data_reg[63];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_sinv
         assign round_out[4*gi +: 4] = sbox_inv(pinv_out[4*gi +: 4]) ^ key_reg[16 + 4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         key_reg   <= '0;
         data_reg  <= '0;
         cnt_reg   <= '0;
         busy      <= 1'b0;
         ready     <= 1'b0;
         msg       <= '0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  key_reg   <= key;
                  data_reg  <= cipher;
                  cnt_reg   <= 5'd1;
                  busy      <= 1'b1;
                  ready     <= 1'b0;
                  state_reg <= KEYEXP;
               end
            end
            KEYEXP: begin
               key_reg <= key_fwd(key_reg, cnt_reg);
               if (cnt_reg == 5'd31) begin
                  state_reg <= WHITEN;
               end else begin
                  cnt_reg <= cnt_reg + 5'd1;
               end
            end
            WHITEN: begin
               data_reg  <= data_reg ^ key_reg[79:16];
               key_reg   <= key_inv(key_reg, 5'd31);
               cnt_reg   <= 5'd31;
               state_reg <= DEC;
            end
            DEC: begin
               data_reg <= round_out;
               if (cnt_reg == 5'd1) begin
                  msg       <= round_out;
                  ready     <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= DONE;
               end else begin
                  // Key for the next (lower) round uses that round's counter value.
                  key_reg <= key_inv(key_reg, cnt_reg - 5'd1);
                  cnt_reg <= cnt_reg - 5'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_present_decrypt.sv
// Scoreboard bench for present_decrypt: known-answer vectors, ignored starts,
// mid-run reset and random loopback through a behavioural PRESENT-80 encryptor.
module tb_present_decrypt;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [63:0] cipher = '0;
   logic [79:0] key = '0;
   logic        busy;
   logic        ready;
   logic [63:0] msg;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [63:0] exp;
      int          e0;
   } item_t;

   item_t       sb[$];
   logic        ready_q = 1'b0;
   logic [63:0] prev_exp = '0;

   present_decrypt dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .cipher(cipher),
      .key(key),
      .busy(busy),
      .ready(ready),
      .msg(msg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] ref_sbox(input logic [3:0] x);
      logic [63:0] tbl;
      tbl = 64'h21748FE3DA09B65C;
      return tbl[4*x +: 4];
   endfunction

   // Textbook PRESENT-80 encryption, written from the cipher definition.
   function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [79:0] k);
      logic [63:0] s;
      logic [63:0] t;
      logic [79:0] kk;
      s  = p;
      kk = k;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ kk[79:16];
         for (int n = 0; n < 16; n++) t[4*n +: 4] = ref_sbox(s[4*n +: 4]);
         for (int b = 0; b < 63; b++) s[(16 * b) % 63] = t[b];
         s[63] = t[63];
         kk = {kk[18:0], kk[79:19]};
         kk[79:76] = ref_sbox(kk[79:76]);
         kk[19:15] = kk[19:15] ^ 5'(r);
      end
      return s ^ kk[79:16];
   endfunction

   function automatic logic [79:0] rand_key();
      return {$urandom(), $urandom(), 16'($urandom())};
   endfunction

   // Monitor: on each rising ready, pop the oldest expectation and compare.
   always @(negedge clk) begin
      item_t it;
      if (rst && ready && !ready_q) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_result: got msg=%h, no request outstanding", msg);
         end else begin
            it = sb.pop_front();
            if (msg !== it.exp) begin
               bad++;
               $display("FAIL msg: got %h want %h", msg, it.exp);
            end
            total++;
            if (cyc - it.e0 != 63) begin
               bad++;
               $display("FAIL latency: got %0d want 63", cyc - it.e0);
            end
         end
      end
      ready_q = ready;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic run_vec(input logic [63:0] c, input logic [79:0] k, input logic [63:0] exp,
                          input int ign_at);
      int   n;
      logic busy_ok;
      @(negedge clk);
      start  = 1'b1;
      cipher = c;
      key    = k;
      sb.push_back('{exp, cyc + 1});
      @(negedge clk);
      start  = 1'b0;
      cipher = {$urandom(), $urandom()};
      key    = rand_key();
      check("ready_drop", 64'(ready), 64'd0);
      check("msg_hold", msg, prev_exp);
      busy_ok = 1'b1;
      n = 0;
      while (!ready && n < 100) begin
         if (!busy) busy_ok = 1'b0;
         if (n == ign_at) begin
            start  = 1'b1;
            cipher = {$urandom(), $urandom()};
            key    = rand_key();
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("ready_timeout", 64'(ready), 64'd1);
      check("busy_hold", 64'(busy_ok), 64'd1);
      check("busy_after", 64'(busy), 64'd0);
      prev_exp = exp;
   endtask

   initial begin
      logic [63:0] p;
      logic [79:0] k;
      logic [79:0] kf;
      kf = '1;

      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ready", 64'(ready), 64'd0);
      check("rst_msg", msg, 64'd0);
      rst = 1'b1;

      run_vec(64'h5579C1387B228445, 80'd0, 64'h0, -1);
      run_vec(64'hE72C46C0F5945049, kf, 64'h0, -1);
      run_vec(64'hA112FFC72F68417B, 80'd0, '1, -1);
      run_vec(64'h3333DCD3213210D2, kf, '1, -1);

      // Start pulse in the middle of a run must be ignored.
      p = {$urandom(), $urandom()};
      k = rand_key();
      run_vec(ref_encrypt(p, k), k, p, 19);

      // Asynchronous abort at cycle 40 of a run.
      @(negedge clk);
      start  = 1'b1;
      cipher = {$urandom(), $urandom()};
      key    = rand_key();
      sb.push_back('{64'h0, cyc + 1});
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ready", 64'(ready), 64'd0);
      check("abort_msg", msg, 64'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      prev_exp = '0;

      for (int i = 0; i < 1000; i++) begin
         p = {$urandom(), $urandom()};
         k = rand_key();
         run_vec(ref_encrypt(p, k), k, p, -1);
      end

      repeat (2) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
